// File: rtl/mfm_sync_decoder.sv
// MFM sync hunter and decoder: finds the sync word in the recovered cell
// stream, frames 16-cell words and strips clock cells into data bytes.
//
// Ports:
//   clk_k     system clock, all logic on posedge
//   rst       synchronous active-high reset
//   cell_stb  one strobe per recovered bit cell
//   cell_dat  cell value, qualified by cell_stb
//   lck       PLL lock; low forces a return to hunt
//   dat_o     decoded byte, MSB first
//   dat_stb   dat_o valid strobe
//   sync_stb  sync word matched strobe
//   err_stb   MFM violation in the byte's raw word (with dat_stb)
//   busy      high while framing data words
//   byte_cnt  bytes emitted since the last sync
module mfm_sync_decoder #(
    parameter logic [15:0] SYNC_WORD = 16'h4489,
    parameter int          MAX_BYTES = 1088,
    parameter int          CNT_W     = 11
) (
    input  logic             clk_k,
    input  logic             rst,
    input  logic             cell_stb,
    input  logic             cell_dat,
    input  logic             lck,
    output logic [7:0]       dat_o,
    output logic             dat_stb,
    output logic             sync_stb,
    output logic             err_stb,
    output logic             busy,
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic {
        HUNT,
        DATA
    } state_e;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BYTES);

    state_e           state_q;
    logic [15:0]      sr_q;
    logic [15:0]      sr_d;
    logic [3:0]       cell_cnt_q;
    logic             prev_q;
    logic             match;
    logic             viol;
    logic [16:0]      span;
    logic [7:0]       byte_d;
    logic [CNT_W-1:0] byte_cnt_d;

    assign sr_d       = {sr_q[14:0], cell_dat};
    assign match      = cell_stb && (sr_d == SYNC_WORD);
    assign byte_cnt_d = byte_cnt + 1'b1;

    // Data cells sit in the odd-numbered slots of the raw word,
    // i.e. the even bit positions of the shift register.
    assign byte_d = {sr_d[14], sr_d[12], sr_d[10], sr_d[8],
                     sr_d[6],  sr_d[4],  sr_d[2],  sr_d[0]};

    // The last cell of the previous word joins the span so that
    // violations straddling the word boundary are caught too.
    always_comb begin
        span = {prev_q, sr_d};
        viol = |(span[16:1] & span[15:0]);
        for (int i = 0; i < 14; i++) begin
            if (span[i +: 4] == 4'b0000) begin
                viol = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_k) begin
        if (rst) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            cell_cnt_q <= '0;
            prev_q     <= 1'b0;
            dat_o      <= '0;
            dat_stb    <= 1'b0;
            sync_stb   <= 1'b0;
            err_stb    <= 1'b0;
            busy       <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            dat_stb  <= 1'b0;
            sync_stb <= 1'b0;
            err_stb  <= 1'b0;
            if (!lck) begin
                state_q    <= HUNT;
                busy       <= 1'b0;
                cell_cnt_q <= '0;
                sr_q       <= '0;
            end else if (cell_stb) begin
                sr_q <= sr_d;
                if (match) begin
                    // Sync realigns framing from any position.
                    state_q    <= DATA;
                    busy       <= 1'b1;
                    sync_stb   <= 1'b1;
                    cell_cnt_q <= '0;
                    byte_cnt   <= '0;
                    prev_q     <= sr_d[0];
                end else if (state_q == DATA) begin
                    cell_cnt_q <= cell_cnt_q + 4'd1;
                    if (cell_cnt_q == 4'd15) begin
                        dat_o   <= byte_d;
                        dat_stb <= 1'b1;
                        err_stb <= viol;
                        prev_q  <= sr_d[0];
                        if (byte_cnt < MAX_C) begin
                            byte_cnt <= byte_cnt_d;
                        end
                        // Last permitted byte: emit it, then stop framing.
                        if (byte_cnt_d >= MAX_C) begin
                            state_q <= HUNT;
                            busy    <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mfm_sync_decoder.sv
// Directed bench for mfm_sync_decoder: sync hunt, decode, violations,
// realignment, lock loss, byte limit and mid-word reset.
module tb_mfm_sync_decoder;

    localparam int CNT_W = 11;

    logic             clk_k;
    logic             rst;
    logic             cell_stb;
    logic             cell_dat;
    logic             lck;
    logic [7:0]       dat_o;
    logic             dat_stb;
    logic             sync_stb;
    logic             err_stb;
    logic             busy;
    logic [CNT_W-1:0] byte_cnt;

    int n_chk;
    int n_fail;
    int n_sync;
    int n_dat;
    int n_err;
    logic [7:0] blog [0:15];
    logic       elog [0:15];

    mfm_sync_decoder #(
        .SYNC_WORD (16'h4489),
        .MAX_BYTES (3),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_k    (clk_k),
        .rst      (rst),
        .cell_stb (cell_stb),
        .cell_dat (cell_dat),
        .lck      (lck),
        .dat_o    (dat_o),
        .dat_stb  (dat_stb),
        .sync_stb (sync_stb),
        .err_stb  (err_stb),
        .busy     (busy),
        .byte_cnt (byte_cnt)
    );

    initial clk_k = 1'b0;
    always #5 clk_k = ~clk_k;

    always @(negedge clk_k) begin
        if (sync_stb) n_sync++;
        if (err_stb) n_err++;
        if (dat_stb) begin
            if (n_dat < 16) begin
                blog[n_dat] = dat_o;
                elog[n_dat] = err_stb;
            end
            n_dat++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_sync = 0;
        n_dat  = 0;
        n_err  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_k);
        rst      = 1'b1;
        lck      = 1'b1;
        cell_stb = 1'b0;
        repeat (4) @(negedge clk_k);
        rst = 1'b0;
        #1;
        clr();
    endtask

    task automatic send_cell(input logic b);
        @(negedge clk_k);
        cell_stb = 1'b1;
        cell_dat = b;
        @(negedge clk_k);
        cell_stb = 1'b0;
        #1;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_cell(w[i]);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_bits(w, 16);
    endtask

    int n0;

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        lck      = 1'b1;
        cell_stb = 1'b0;
        cell_dat = 1'b0;
        clr();

        do_reset();
        check("rst_dat", dat_o, 8'h00);
        check("rst_dstb", dat_stb, 1'b0);
        check("rst_sync", sync_stb, 1'b0);
        check("rst_err", err_stb, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", byte_cnt, 0);

        // Hunt then sync
        send_word(16'hF0F0);
        check("hunt_nosync", n_sync, 0);
        check("hunt_busy", busy, 1'b0);
        send_word(16'h4489);
        check("sync_lat", sync_stb, 1'b1);
        check("sync_cnt", n_sync, 1);
        check("sync_busy", busy, 1'b1);
        check("sync_bcnt", byte_cnt, 0);
        check("hunt_nodat", n_dat, 0);
        @(negedge clk_k);
        #1;
        check("sync_width", sync_stb, 1'b0);
        check("sync_cnt2", n_sync, 1);

        // Decode
        do_reset();
        send_word(16'h4489);
        send_word(16'h5555);
        check("dec_lat", dat_stb, 1'b1);
        check("dec_b0", blog[0], 8'hFF);
        send_word(16'h2AAA);
        check("dec_b1", blog[1], 8'h00);
        check("dec_ndat", n_dat, 2);
        check("dec_nerr", n_err, 0);
        check("dec_bcnt", byte_cnt, 2);
        check("dec_busy", busy, 1'b1);

        // Violation across word boundary
        do_reset();
        send_word(16'h4489);
        send_word(16'hAAAA);
        check("vio_dstb", dat_stb, 1'b1);
        check("vio_estb", err_stb, 1'b1);
        check("vio_dat", dat_o, 8'h00);
        check("vio_bcnt", byte_cnt, 1);

        // Double sync and realignment
        do_reset();
        send_word(16'h4489);
        send_word(16'h4489);
        check("dbl_nsync", n_sync, 2);
        check("dbl_ndat", n_dat, 0);
        send_word(16'h5555);
        check("dbl_b0", blog[0], 8'hFF);
        send_bits(16'h000A, 5);
        send_word(16'h4489);
        check("rea_nsync", n_sync, 3);
        check("rea_stb", sync_stb, 1'b1);
        check("rea_ndat", n_dat, 2);
        check("rea_b1", blog[1], 8'hC2);
        check("rea_e1", elog[1], 1'b0);
        check("rea_bcnt", byte_cnt, 0);
        send_bits(16'h2AAA, 15);
        check("rea_early", n_dat, 2);
        send_cell(1'b1);
        check("rea_ndat2", n_dat, 3);
        check("rea_b2", blog[2], 8'hFF);
        check("rea_bcnt2", byte_cnt, 1);

        // Lock loss mid-word
        do_reset();
        send_word(16'h4489);
        send_bits(16'h0015, 6);
        @(negedge clk_k);
        lck      = 1'b0;
        cell_stb = 1'b1;
        cell_dat = 1'b1;
        @(negedge clk_k);
        cell_stb = 1'b0;
        @(negedge clk_k);
        lck = 1'b1;
        #1;
        check("lck_busy", busy, 1'b0);
        send_bits(16'h0155, 10);
        check("lck_ndat", n_dat, 0);
        check("lck_busy2", busy, 1'b0);

        // Byte limit
        send_word(16'h4489);
        check("lim_sync", n_sync, 2);
        send_word(16'h5555);
        send_word(16'h5555);
        check("lim_ndat2", n_dat, 2);
        check("lim_busy2", busy, 1'b1);
        send_word(16'h5555);
        check("lim_dstb", dat_stb, 1'b1);
        check("lim_busy3", busy, 1'b0);
        check("lim_bcnt3", byte_cnt, 3);
        send_word(16'h5555);
        check("lim_ndat4", n_dat, 3);
        check("lim_bcnt4", byte_cnt, 3);

        // Reset mid-word
        do_reset();
        send_word(16'h4489);
        send_word(16'h5555);
        send_bits(16'h0155, 10);
        n0 = n_dat;
        @(negedge clk_k);
        rst = 1'b1;
        @(negedge clk_k);
        rst = 1'b0;
        #1;
        check("mrst_dat", dat_o, 8'h00);
        check("mrst_bcnt", byte_cnt, 0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_dstb", dat_stb, 1'b0);
        check("mrst_sstb", sync_stb, 1'b0);
        check("mrst_ndat", n_dat, n0);
        send_bits(16'h0015, 6);
        send_word(16'h4489);
        check("mrst_sync", sync_stb, 1'b1);
        check("mrst_busy2", busy, 1'b1);
        send_word(16'h5555);
        check("mrst_ndat2", n_dat, n0 + 1);
        check("mrst_b", dat_o, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
